// File: rtl/mips_ctrl_fsm.sv
// Multicycle MIPS control FSM: FETCH, DECODE, EXEC, MEM, WB.
// Drives datapath selects, write strobes, a sticky illegal flag and a retire count.
//
// Ports:
//   clk, reset           rising-edge clock, async active-high reset
//   op, funct            instruction fields, sampled in DECODE
//   cmp_eq               rs==rt compare, used for beq in DECODE
//   mem_ready            data memory completion, honoured only in MEM
//   Wreg_sel, ALU_B_sel, Wdata_sel, PC_sel, b_j_jr_sel   datapath selects
//   pc_we, ir_we, reg_we, mem_re, mem_we                 strobes
//   alu_op, ext_sign     ALU function and imm16 extension mode
//   illegal              sticky unsupported-instruction flag
//   instr_cnt            retired instruction count (wraps)
module mips_ctrl_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        cmp_eq,
    input  logic        mem_ready,
    output logic [1:0]  Wreg_sel,
    output logic        ALU_B_sel,
    output logic [1:0]  Wdata_sel,
    output logic        PC_sel,
    output logic [1:0]  b_j_jr_sel,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_re,
    output logic        mem_we,
    output logic [1:0]  alu_op,
    output logic        ext_sign,
    output logic        illegal,
    output logic [31:0] instr_cnt
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI,
        K_LW, K_SW, K_BEQ, K_J, K_JAL, K_BAD
    } kind_t;

    function automatic kind_t decode(input logic [5:0] o,
                                     input logic [5:0] f);
        kind_t k;
        case (o)
            6'h00: begin
                case (f)
                    6'h21:   k = K_ADDU;
                    6'h23:   k = K_SUBU;
                    6'h08:   k = K_JR;
                    default: k = K_BAD;
                endcase
            end
            6'h0D:   k = K_ORI;
            6'h0F:   k = K_LUI;
            6'h23:   k = K_LW;
            6'h2B:   k = K_SW;
            6'h04:   k = K_BEQ;
            6'h02:   k = K_J;
            6'h03:   k = K_JAL;
            default: k = K_BAD;
        endcase
        return k;
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  op_q;
    logic [5:0]  funct_q;
    kind_t       kind_in;
    kind_t       kind_q;
    logic        cnt_inc;

    // DECODE looks at the live bus; later states only trust the latched copy.
    assign kind_in = decode(op, funct);
    assign kind_q  = decode(op_q, funct_q);

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH: state_nxt = DECODE;
            DECODE: begin
                case (kind_in)
                    K_J, K_JR, K_BEQ, K_BAD: state_nxt = FETCH;
                    K_JAL:                   state_nxt = WB;
                    default:                 state_nxt = EXEC;
                endcase
            end
            EXEC: begin
                if (kind_q == K_LW || kind_q == K_SW)
                    state_nxt = MEM;
                else
                    state_nxt = WB;
            end
            MEM: begin
                if (kind_q != K_LW && kind_q != K_SW)
                    state_nxt = FETCH;
                else if (!mem_ready)
                    state_nxt = MEM;
                else if (kind_q == K_LW)
                    state_nxt = WB;
                else
                    state_nxt = FETCH;
            end
            WB:      state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // Only retirement paths count; the FETCH->DECODE step never does.
    assign cnt_inc = (state_nxt == FETCH) &&
                     (state == DECODE || state == MEM || state == WB);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            op_q      <= '0;
            funct_q   <= '0;
            illegal   <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == DECODE) begin
                op_q    <= op;
                funct_q <= funct;
                if (kind_in == K_BAD)
                    illegal <= 1'b1;
            end
            if (cnt_inc)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end

    // Outputs are combinational so reset can kill memory strobes immediately.
    always_comb begin
        Wreg_sel   = 2'd0;
        ALU_B_sel  = 1'b0;
        Wdata_sel  = 2'd0;
        PC_sel     = 1'b0;
        b_j_jr_sel = 2'd0;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        alu_op     = 2'd0;
        ext_sign   = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
                DECODE: begin
                    case (kind_in)
                        K_J, K_JAL: begin
                            PC_sel     = 1'b1;
                            b_j_jr_sel = 2'd1;
                            pc_we      = 1'b1;
                        end
                        K_JR: begin
                            PC_sel     = 1'b1;
                            b_j_jr_sel = 2'd2;
                            pc_we      = 1'b1;
                        end
                        K_BEQ: begin
                            PC_sel   = 1'b1;
                            ext_sign = 1'b1;
                            pc_we    = cmp_eq;
                        end
                        default: ;
                    endcase
                end
                EXEC: begin
                    case (kind_q)
                        K_SUBU: alu_op = 2'd1;
                        K_ORI: begin
                            ALU_B_sel = 1'b1;
                            alu_op    = 2'd2;
                        end
                        K_LUI: begin
                            ALU_B_sel = 1'b1;
                            alu_op    = 2'd3;
                        end
                        K_LW, K_SW: begin
                            ALU_B_sel = 1'b1;
                            ext_sign  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    mem_re = (kind_q == K_LW);
                    mem_we = (kind_q == K_SW);
                end
                WB: begin
                    reg_we = 1'b1;
                    case (kind_q)
                        K_ADDU, K_SUBU: Wreg_sel = 2'd1;
                        K_LW:           Wdata_sel = 2'd1;
                        K_JAL: begin
                            Wreg_sel  = 2'd2;
                            Wdata_sel = 2'd2;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
